// File: rtl/tl_pkg.sv
// Phase encodings and small helpers shared by the scheduler, the legacy
// traffic-light FSM and the lamp decoders.
package tl_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t PH_EW     = 3'b000;
    localparam phase_t PH_EY     = 3'b001;
    localparam phase_t PH_NY     = 3'b010;
    localparam phase_t PH_NS     = 3'b011;
    localparam phase_t PH_WALK   = 3'b100;
    localparam phase_t PH_ALLRED = 3'b111;

    // One bit per servable phase; used for pending requests and acks.
    typedef struct packed {
        logic ns;
        logic ew;
        logic ped;
    } req_t;

    // Yellow phase that follows a given green.
    function automatic phase_t yellow_of(input phase_t green);
        return (green == PH_NS) ? PH_NY : PH_EY;
    endfunction

endpackage

// File: rtl/tl_timer.sv
// Phase timer: load, down-count to zero, or up-count saturating at i_sat.
module tl_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_up,
    input  logic [W-1:0] i_sat,
    output logic [W-1:0] o_value,
    output logic         o_zero
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next value: load wins, otherwise count in the selected direction.
    always_comb begin
        value_d = value_q;
        if (i_en) begin
            if (i_load) begin
                value_d = i_load_val;
            end else if (i_up) begin
                if (value_q < i_sat) begin
                    value_d = value_q + 1'b1;
                end
            end else if (value_q != '0) begin
                value_d = value_q - 1'b1;
            end
        end
    end

    // Timer register; clear returns to the configured reset value.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            value_q <= CLR_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;
    assign o_zero  = (value_q == '0);

endmodule

// File: rtl/tl_phase_sched.sv
// Demand-actuated phase scheduler: latches requests, arbitrates between
// NS/EW greens and a pedestrian WALK, and sequences yellow/all-red.
module tl_phase_sched
    import tl_pkg::*;
#(
    parameter int T_WIDTH   = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int Y_TIME    = 3,
    parameter int AR_TIME   = 1,
    parameter int WALK_TIME = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_req_ns,
    input  logic               i_req_ew,
    input  logic               i_req_ped,
    input  logic               i_ext_ns,
    input  logic               i_ext_ew,
    output logic [2:0]         o_state,
    output logic               o_ack_ns,
    output logic               o_ack_ew,
    output logic               o_ack_ped,
    output logic [T_WIDTH-1:0] o_remain
);

    localparam logic [T_WIDTH-1:0] MIN_G1 = T_WIDTH'(MIN_GREEN - 1);
    localparam logic [T_WIDTH-1:0] MAX_G1 = T_WIDTH'(MAX_GREEN - 1);
    localparam logic [T_WIDTH-1:0] Y_LD   = T_WIDTH'(Y_TIME - 1);
    localparam logic [T_WIDTH-1:0] AR_LD  = T_WIDTH'(AR_TIME - 1);
    localparam logic [T_WIDTH-1:0] WK_LD  = T_WIDTH'(WALK_TIME - 1);

    phase_t state_q, state_d;
    req_t   pend_q,  pend_d;
    req_t   ack_q,   ack_d;
    logic   last_ns_q, last_ns_d;   // 1: last green was NS, 0: EW

    req_t   req_in;
    req_t   pend_eff;
    phase_t next_phase;
    logic   in_ns;
    logic   conflict;
    logic   ext_cur;
    logic   opp_pending;
    logic   any_dir;

    logic               tmr_load;
    logic               tmr_up;
    logic [T_WIDTH-1:0] tmr_val;
    logic [T_WIDTH-1:0] tmr_value;
    logic               tmr_zero;

    tl_timer #(
        .W       (T_WIDTH),
        .CLR_VAL (AR_LD)
    ) u_timer (
        .i_clk      (i_clk),
        .i_clr      (i_rst),
        .i_en       (i_en),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .i_up       (tmr_up),
        .i_sat      (MAX_G1),
        .o_value    (tmr_value),
        .o_zero     (tmr_zero)
    );

    // Phase selection, green leave decision, pending/ack bookkeeping.
    always_comb begin
        req_in.ns   = i_req_ns;
        req_in.ew   = i_req_ew;
        req_in.ped  = i_req_ped;

        // Arbitration out of all-red sees this cycle's requests too, so a
        // request can select a phase on the edge that ends its cycle.
        pend_eff.ns  = pend_q.ns  | req_in.ns;
        pend_eff.ew  = pend_q.ew  | req_in.ew;
        pend_eff.ped = pend_q.ped | req_in.ped;

        state_d    = state_q;
        last_ns_d  = last_ns_q;
        ack_d      = '0;
        pend_d     = pend_eff;
        tmr_load   = 1'b0;
        tmr_up     = 1'b0;
        tmr_val    = '0;
        next_phase = PH_ALLRED;

        in_ns       = (state_q == PH_NS);
        conflict    = in_ns ? (pend_q.ew | pend_q.ped) : (pend_q.ns | pend_q.ped);
        ext_cur     = in_ns ? i_ext_ns : i_ext_ew;
        opp_pending = last_ns_q ? pend_eff.ew : pend_eff.ns;
        any_dir     = pend_eff.ns | pend_eff.ew;

        if (i_en) begin
            case (state_q)
                PH_ALLRED: begin
                    if (tmr_zero) begin
                        if (pend_eff.ped) begin
                            next_phase = PH_WALK;
                        end else if (opp_pending || !any_dir) begin
                            next_phase = last_ns_q ? PH_EW : PH_NS;
                        end else begin
                            next_phase = last_ns_q ? PH_NS : PH_EW;
                        end
                        state_d  = next_phase;
                        tmr_load = 1'b1;
                        case (next_phase)
                            PH_WALK: begin
                                tmr_val    = WK_LD;
                                ack_d.ped  = pend_eff.ped;
                                pend_d.ped = 1'b0;
                            end
                            PH_NS: begin
                                last_ns_d = 1'b1;
                                ack_d.ns  = pend_eff.ns;
                                pend_d.ns = 1'b0;
                            end
                            default: begin
                                last_ns_d = 1'b0;
                                ack_d.ew  = pend_eff.ew;
                                pend_d.ew = 1'b0;
                            end
                        endcase
                    end
                end
                PH_NS, PH_EW: begin
                    // Timer holds elapsed green cycles here.
                    if ((tmr_value >= MIN_G1) && conflict &&
                        (!ext_cur || (tmr_value == MAX_G1))) begin
                        state_d  = yellow_of(state_q);
                        tmr_load = 1'b1;
                        tmr_val  = Y_LD;
                    end else begin
                        tmr_up = 1'b1;
                    end
                end
                PH_NY, PH_EY, PH_WALK: begin
                    if (tmr_zero) begin
                        state_d  = PH_ALLRED;
                        tmr_load = 1'b1;
                        tmr_val  = AR_LD;
                    end
                end
                default: begin
                    state_d  = PH_ALLRED;
                    tmr_load = 1'b1;
                    tmr_val  = AR_LD;
                end
            endcase
        end
    end

    // Scheduler state: phase, pending requests, last green and acks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= PH_ALLRED;
            pend_q    <= '0;
            last_ns_q <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            last_ns_q <= last_ns_d;
            ack_q     <= ack_d;
        end
    end

    assign o_state   = state_q;
    assign o_ack_ns  = ack_q.ns;
    assign o_ack_ew  = ack_q.ew;
    assign o_ack_ped = ack_q.ped;
    assign o_remain  = tmr_value;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed bench for tl_phase_sched with hand-computed expectations.
module tb_tl_phase_sched;

    localparam logic [2:0] S_EW = 3'b000;
    localparam logic [2:0] S_EY = 3'b001;
    localparam logic [2:0] S_NY = 3'b010;
    localparam logic [2:0] S_NS = 3'b011;
    localparam logic [2:0] S_WK = 3'b100;
    localparam logic [2:0] S_AR = 3'b111;

    logic       clk = 1'b0;
    logic       rst, en, req_ns, req_ew, req_ped, ext_ns, ext_ew;
    logic [2:0] state;
    logic       ack_ns, ack_ew, ack_ped;
    logic [7:0] remain;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tl_phase_sched dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_req_ns  (req_ns),
        .i_req_ew  (req_ew),
        .i_req_ped (req_ped),
        .i_ext_ns  (ext_ns),
        .i_ext_ew  (ext_ew),
        .o_state   (state),
        .o_ack_ns  (ack_ns),
        .o_ack_ew  (ack_ew),
        .o_ack_ped (ack_ped),
        .o_remain  (remain)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transaction = one observed cycle: phase, timer and ack vector.
    task automatic cyc(input string tag, input logic [2:0] st, input int rem, input logic [2:0] acks);
        $display("t=%0t %s state=%b remain=%0d acks=%b", $time, tag, state, remain, {ack_ns, ack_ew, ack_ped});
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".remain"}, 32'(remain), 32'(rem));
        chk({tag, ".acks"}, 32'({ack_ns, ack_ew, ack_ped}), 32'(acks));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        req_ns = 1'b0; req_ew = 1'b0; req_ped = 1'b0;
        ext_ns = 1'b0; ext_ew = 1'b0;

        // Reset state, then rest in NS with no demand.
        step(); step();
        cyc("reset", S_AR, 0, 3'b000);
        rst = 1'b0;
        step();
        cyc("boot_ns", S_NS, 0, 3'b000);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("ns_hold.state", 32'(state), 32'(S_NS));
            chk("ns_hold.acks", 32'({ack_ns, ack_ew, ack_ped}), 32'd0);
        end
        cyc("ns_sat", S_NS, 11, 3'b000);

        // EW request at elapsed 1: minimum green then EW with ack.
        do_reset();
        step(); cyc("t2_ns0", S_NS, 0, 3'b000);
        step(); cyc("t2_ns1", S_NS, 1, 3'b000);
        req_ew = 1'b1; step(); req_ew = 1'b0;
        cyc("t2_ns2", S_NS, 2, 3'b000);
        step(); cyc("t2_ns3", S_NS, 3, 3'b000);
        step(); cyc("t2_ny2", S_NY, 2, 3'b000);
        step(); cyc("t2_ny1", S_NY, 1, 3'b000);
        step(); cyc("t2_ny0", S_NY, 0, 3'b000);
        step(); cyc("t2_ar", S_AR, 0, 3'b000);
        step(); cyc("t2_ew0", S_EW, 0, 3'b010);
        step(); cyc("t2_ew1", S_EW, 1, 3'b000);

        // Extension holds NS to MAX_GREEN; then freeze NY at timer 1.
        do_reset();
        step(); cyc("t3_ns0", S_NS, 0, 3'b000);
        ext_ns = 1'b1; req_ew = 1'b1; step(); req_ew = 1'b0;
        cyc("t3_ns1", S_NS, 1, 3'b000);
        for (int k = 2; k <= 11; k++) begin
            step(); cyc("t3_ns", S_NS, k, 3'b000);
        end
        step(); cyc("t3_ny2", S_NY, 2, 3'b000);
        step(); cyc("t3_ny1", S_NY, 1, 3'b000);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); cyc("t5_frozen", S_NY, 1, 3'b000);
        end
        en = 1'b1;
        step(); cyc("t5_ny0", S_NY, 0, 3'b000);
        ext_ns = 1'b0;
        step(); cyc("t5_ar", S_AR, 0, 3'b000);
        step(); cyc("t5_ew0", S_EW, 0, 3'b010);

        // Pedestrian request during EW elapsed 5.
        for (int k = 1; k <= 5; k++) begin
            step(); cyc("t4_ew", S_EW, k, 3'b000);
        end
        req_ped = 1'b1; step(); req_ped = 1'b0;
        cyc("t4_ew6", S_EW, 6, 3'b000);
        step(); cyc("t4_ey2", S_EY, 2, 3'b000);
        step(); cyc("t4_ey1", S_EY, 1, 3'b000);
        step(); cyc("t4_ey0", S_EY, 0, 3'b000);
        step(); cyc("t4_ar1", S_AR, 0, 3'b000);
        step(); cyc("t4_wk5", S_WK, 5, 3'b001);
        for (int k = 4; k >= 0; k--) begin
            step(); cyc("t4_wk", S_WK, k, 3'b000);
        end
        step(); cyc("t4_ar2", S_AR, 0, 3'b000);
        step(); cyc("t4_ns0", S_NS, 0, 3'b000);

        // Reset mid-EW with NS pending discards the request.
        req_ew = 1'b1; step(); req_ew = 1'b0;
        cyc("t6_ns1", S_NS, 1, 3'b000);
        step(); cyc("t6_ns2", S_NS, 2, 3'b000);
        step(); cyc("t6_ns3", S_NS, 3, 3'b000);
        step(); cyc("t6_ny2", S_NY, 2, 3'b000);
        step(); cyc("t6_ny1", S_NY, 1, 3'b000);
        step(); cyc("t6_ny0", S_NY, 0, 3'b000);
        step(); cyc("t6_ar", S_AR, 0, 3'b000);
        step(); cyc("t6_ew0", S_EW, 0, 3'b010);
        step(); cyc("t6_ew1", S_EW, 1, 3'b000);
        req_ns = 1'b1; step(); req_ns = 1'b0;
        cyc("t6_ew2", S_EW, 2, 3'b000);
        rst = 1'b1; step(); rst = 1'b0;
        cyc("t6_rst", S_AR, 0, 3'b000);
        step(); cyc("t6_ns_noack", S_NS, 0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
